pong_ball_engine: RTL and testbench

Pixel-stream consumer placed directly downstream of the VGA timing generator. Takes the raster position (`row`, `col`, `blank`), advances ball physics once per frame, detects wall and paddle bounces, and keeps score. Produces registered 24-bit RGB for the DAC for the ball, both paddles and the background.

---
 rtl/pong_ball_engine.sv | 231 +++++++++++++++++++++++
 tb/tb_pong_ball_engine.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pong_ball_engine.sv
// Pong ball engine: frame-rate ball physics, paddle/wall bounces, scoring and pixel colouring.
// Optional dashed centre net enabled by defining CENTER_LINE_EN.
module pong_ball_engine #(
    parameter int unsigned BALL_SIZE      = 8,
    parameter int unsigned SPEED          = 2,
    parameter int unsigned PADDLE_H       = 48,
    parameter int unsigned PADDLE_W       = 4,
    parameter int unsigned LEFT_PADDLE_X  = 16,
    parameter int unsigned RIGHT_PADDLE_X = 620,
    parameter int unsigned SERVE_DELAY    = 60,
    parameter int unsigned WIN_SCORE      = 9
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [9:0] row,
    input  logic [9:0] col,
    input  logic       blank,
    input  logic [8:0] left_paddle_y,
    input  logic [8:0] right_paddle_y,
    input  logic       serve,
    output logic [7:0] red,
    output logic [7:0] green,
    output logic [7:0] blue,
    output logic [3:0] left_score,
    output logic [3:0] right_score,
    output logic       game_over
);

    localparam int unsigned CntW = $clog2(SERVE_DELAY + 1);

    localparam logic [9:0]  CenterX      = 10'd316;
    localparam logic [8:0]  CenterY      = 9'd236;
    localparam logic [10:0] Spd          = 11'(SPEED);
    localparam logic [10:0] Bs           = 11'(BALL_SIZE);
    localparam logic [10:0] Ph           = 11'(PADDLE_H);
    localparam logic [10:0] LeftX        = 11'(LEFT_PADDLE_X);
    localparam logic [10:0] RightX       = 11'(RIGHT_PADDLE_X);
    localparam logic [10:0] PadW         = 11'(PADDLE_W);
    localparam logic [10:0] LeftHitX     = 11'(LEFT_PADDLE_X + PADDLE_W);
    localparam logic [10:0] RightHitX    = 11'(RIGHT_PADDLE_X - BALL_SIZE);
    localparam logic [10:0] LeftBounceX  = 11'(LEFT_PADDLE_X + PADDLE_W + SPEED);
    localparam logic [10:0] RightBounceX = 11'(RIGHT_PADDLE_X - BALL_SIZE - SPEED);
    localparam logic [10:0] XMissLim     = 11'(640 - SPEED);
    localparam logic [10:0] YLim         = 11'(480 - SPEED);
    localparam logic [10:0] YBottom      = 11'(480 - BALL_SIZE);

    typedef enum logic [2:0] {
        StIdle,
        StServeWait,
        StPlay,
        StScored,
        StOver
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [9:0]        bx_q, bx_d;
    logic [8:0]        by_q, by_d;
    logic              dx_q, dx_d;
    logic              dy_q, dy_d;
    logic [3:0]        ls_q, ls_d;
    logic [3:0]        rs_q, rs_d;
    logic              left_won_q, left_won_d;
    logic              at_vbl_q;
    logic [23:0]       rgb_q, rgb_d;

    logic              at_vbl, tick;
    logic [10:0]       bx11, by11, lpy11, rpy11, row11, col11;
    logic              left_hit, right_hit, h_miss;
    logic              in_ball, in_lpad, in_rpad, on_net;

    assign at_vbl = (row == 10'd480) && (col == 10'd0);
    assign tick   = at_vbl && !at_vbl_q;

    assign bx11  = {1'b0, bx_q};
    assign by11  = {2'b0, by_q};
    assign lpy11 = {2'b0, left_paddle_y};
    assign rpy11 = {2'b0, right_paddle_y};
    assign row11 = {1'b0, row};
    assign col11 = {1'b0, col};

    assign left_hit  = !dx_q && (bx11 <= LeftHitX) &&
                       (by11 + Bs > lpy11) && (by11 < lpy11 + Ph);
    assign right_hit = dx_q && (bx11 >= RightHitX) &&
                       (by11 + Bs > rpy11) && (by11 < rpy11 + Ph);
    // Hits take priority over misses; a miss freezes the ball for this tick.
    assign h_miss    = !left_hit && !right_hit &&
                       ((!dx_q && (bx11 < Spd)) || (dx_q && (bx11 + Bs > XMissLim)));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bx_d       = bx_q;
        by_d       = by_q;
        dx_d       = dx_q;
        dy_d       = dy_q;
        ls_d       = ls_q;
        rs_d       = rs_q;
        left_won_d = left_won_q;
        if (tick) begin
            case (state_q)
                StIdle: begin
                    bx_d = CenterX;
                    by_d = CenterY;
                    if (serve) begin
                        state_d = StServeWait;
                        cnt_d   = '0;
                    end
                end
                StServeWait: begin
                    if (cnt_q == CntW'(SERVE_DELAY - 1)) begin
                        state_d = StPlay;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StPlay: begin
                    if (h_miss) begin
                        state_d    = StScored;
                        left_won_d = dx_q;
                    end else begin
                        if (left_hit) begin
                            dx_d = 1'b1;
                            bx_d = 10'(LeftBounceX);
                        end else if (right_hit) begin
                            dx_d = 1'b0;
                            bx_d = 10'(RightBounceX);
                        end else if (dx_q) begin
                            bx_d = bx_q + 10'(SPEED);
                        end else begin
                            bx_d = bx_q - 10'(SPEED);
                        end
                        if (!dy_q && (by11 < Spd)) begin
                            dy_d = 1'b1;
                            by_d = '0;
                        end else if (dy_q && (by11 + Bs > YLim)) begin
                            dy_d = 1'b0;
                            by_d = 9'(YBottom);
                        end else if (dy_q) begin
                            by_d = by_q + 9'(SPEED);
                        end else begin
                            by_d = by_q - 9'(SPEED);
                        end
                    end
                end
                StScored: begin
                    bx_d  = CenterX;
                    by_d  = CenterY;
                    cnt_d = '0;
                    // Serve towards the player who conceded.
                    dx_d  = left_won_q;
                    if (left_won_q) begin
                        ls_d = ls_q + 4'd1;
                    end else begin
                        rs_d = rs_q + 4'd1;
                    end
                    if ((ls_d == 4'(WIN_SCORE)) || (rs_d == 4'(WIN_SCORE))) begin
                        state_d = StOver;
                    end else begin
                        state_d = StServeWait;
                    end
                end
                StOver: begin
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign in_ball = (col11 >= bx11) && (col11 < bx11 + Bs) &&
                     (row11 >= by11) && (row11 < by11 + Bs);
    assign in_lpad = (col11 >= LeftX) && (col11 < LeftX + PadW) &&
                     (row11 >= lpy11) && (row11 < lpy11 + Ph);
    assign in_rpad = (col11 >= RightX) && (col11 < RightX + PadW) &&
                     (row11 >= rpy11) && (row11 < rpy11 + Ph);

`ifdef CENTER_LINE_EN
    assign on_net = (col >= 10'd318) && (col <= 10'd321) && !row[4];
`else
    assign on_net = 1'b0;
`endif

    always_comb begin
        rgb_d = 24'h000000;
        if (blank) begin
            rgb_d = 24'h000000;
        end else if (in_ball && (state_q != StOver)) begin
            rgb_d = 24'hFFFFFF;
        end else if (in_lpad || in_rpad) begin
            rgb_d = 24'h00FF00;
        end else if (on_net) begin
            rgb_d = 24'h808080;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            bx_q       <= CenterX;
            by_q       <= CenterY;
            dx_q       <= 1'b1;
            dy_q       <= 1'b1;
            ls_q       <= '0;
            rs_q       <= '0;
            left_won_q <= 1'b0;
            at_vbl_q   <= 1'b0;
            rgb_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bx_q       <= bx_d;
            by_q       <= by_d;
            dx_q       <= dx_d;
            dy_q       <= dy_d;
            ls_q       <= ls_d;
            rs_q       <= rs_d;
            left_won_q <= left_won_d;
            at_vbl_q   <= at_vbl;
            rgb_q      <= rgb_d;
        end
    end

    assign red         = rgb_q[23:16];
    assign green       = rgb_q[15:8];
    assign blue        = rgb_q[7:0];
    assign left_score  = ls_q;
    assign right_score = rs_q;
    assign game_over   = (state_q == StOver);

endmodule

// File: tb/tb_pong_ball_engine.sv
// Directed bench for pong_ball_engine: pixel vectors, a motion/score table and end-of-game sequences.
module tb_pong_ball_engine;

    logic       clk;
    logic       reset;
    logic [9:0] row;
    logic [9:0] col;
    logic       blank;
    logic [8:0] left_paddle_y;
    logic [8:0] right_paddle_y;
    logic       serve;
    logic [7:0] red, green, blue;
    logic [3:0] left_score, right_score;
    logic       game_over;

    int n_cmp  = 0;
    int n_fail = 0;

`ifdef CENTER_LINE_EN
    localparam logic [23:0] NetRgb = 24'h808080;
`else
    localparam logic [23:0] NetRgb = 24'h000000;
`endif

    pong_ball_engine dut (
        .CLOCK_50      (clk),
        .reset         (reset),
        .row           (row),
        .col           (col),
        .blank         (blank),
        .left_paddle_y (left_paddle_y),
        .right_paddle_y(right_paddle_y),
        .serve         (serve),
        .red           (red),
        .green         (green),
        .blue          (blue),
        .left_score    (left_score),
        .right_score   (right_score),
        .game_over     (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "timeout");
    end

    typedef struct {
        int unsigned r;
        int unsigned c;
        bit          b;
        logic [23:0] rgb;
    } pix_t;

    typedef struct {
        int          delta;
        int unsigned bx;
        int unsigned by;
        bit          dx;
        bit          dy;
        bit          chk_y;
        int unsigned ls;
        int unsigned rs;
        int unsigned lpy;
        int unsigned rpy;
        bit          srv;
    } mv_t;

    pix_t pix[18];
    mv_t  mv[25];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One frame boundary: at_vbl is held for two clocks like the real raster.
    task automatic do_tick();
        row   = 10'd480;
        col   = 10'd0;
        blank = 1'b1;
        step();
        step();
        row = 10'd481;
        step();
    endtask

    task automatic pixel(input int unsigned r, input int unsigned c, input bit b);
        row   = 10'(r);
        col   = 10'(c);
        blank = b;
        step();
    endtask

    initial begin
        pix[0]  = '{236, 316, 1, 24'h000000};
        pix[1]  = '{236, 316, 0, 24'hFFFFFF};
        pix[2]  = '{243, 323, 0, 24'hFFFFFF};
        pix[3]  = '{243, 324, 0, 24'h000000};
        pix[4]  = '{244, 316, 0, 24'h000000};
        pix[5]  = '{235, 316, 0, 24'h000000};
        pix[6]  = '{100, 16,  0, 24'h00FF00};
        pix[7]  = '{147, 19,  0, 24'h00FF00};
        pix[8]  = '{100, 20,  0, 24'h000000};
        pix[9]  = '{148, 16,  0, 24'h000000};
        pix[10] = '{99,  16,  0, 24'h000000};
        pix[11] = '{200, 620, 0, 24'h00FF00};
        pix[12] = '{247, 623, 0, 24'h00FF00};
        pix[13] = '{200, 624, 0, 24'h000000};
        pix[14] = '{5,   319, 0, NetRgb};
        pix[15] = '{16,  319, 0, 24'h000000};
        pix[16] = '{5,   319, 1, 24'h000000};
        pix[17] = '{236, 318, 0, 24'hFFFFFF};

        // Serve, rally off both paddles and both walls, then miss on each side.
        mv[0]  = '{1,   316, 236, 1, 1, 1, 0, 0, 166, 404, 1};
        mv[1]  = '{60,  316, 236, 1, 1, 1, 0, 0, 166, 404, 1};
        mv[2]  = '{1,   318, 238, 1, 1, 1, 0, 0, 166, 404, 1};
        mv[3]  = '{116, 550, 470, 1, 1, 1, 0, 0, 166, 404, 0};
        mv[4]  = '{1,   552, 472, 1, 1, 1, 0, 0, 166, 404, 0};
        mv[5]  = '{1,   554, 472, 1, 0, 1, 0, 0, 166, 404, 0};
        mv[6]  = '{29,  612, 414, 1, 0, 1, 0, 0, 166, 404, 0};
        mv[7]  = '{1,   610, 412, 0, 0, 1, 0, 0, 166, 404, 0};
        mv[8]  = '{205, 200, 2,   0, 0, 1, 0, 0, 166, 404, 0};
        mv[9]  = '{1,   198, 0,   0, 0, 1, 0, 0, 166, 404, 0};
        mv[10] = '{1,   196, 0,   0, 1, 1, 0, 0, 166, 404, 0};
        mv[11] = '{88,  20,  176, 0, 1, 1, 0, 0, 166, 404, 0};
        mv[12] = '{1,   22,  178, 1, 1, 1, 0, 0, 166, 404, 0};
        mv[13] = '{305, 632, 158, 1, 0, 1, 0, 0, 511, 48,  0};
        mv[14] = '{1,   632, 0,   1, 0, 0, 0, 0, 511, 48,  0};
        mv[15] = '{1,   316, 236, 1, 0, 1, 1, 0, 511, 48,  0};
        mv[16] = '{60,  316, 236, 1, 0, 1, 1, 0, 511, 48,  0};
        mv[17] = '{1,   318, 234, 1, 0, 1, 1, 0, 511, 48,  0};
        mv[18] = '{117, 552, 0,   1, 0, 1, 1, 0, 511, 48,  0};
        mv[19] = '{1,   554, 0,   1, 1, 1, 1, 0, 511, 48,  0};
        mv[20] = '{29,  612, 58,  1, 1, 1, 1, 0, 511, 48,  0};
        mv[21] = '{1,   610, 60,  0, 1, 1, 1, 0, 511, 48,  0};
        mv[22] = '{305, 0,   276, 0, 0, 1, 1, 0, 511, 48,  0};
        mv[23] = '{1,   0,   0,   0, 0, 0, 1, 0, 511, 48,  0};
        mv[24] = '{1,   316, 236, 0, 0, 1, 1, 1, 511, 48,  0};

        reset          = 1'b1;
        row            = 10'd236;
        col            = 10'd316;
        blank          = 1'b0;
        left_paddle_y  = 9'd100;
        right_paddle_y = 9'd200;
        serve          = 1'b0;
        step();
        step();
        check("reset_rgb", {8'h0, red, green, blue}, 32'h0);
        check("reset_bx", 32'(dut.bx_q), 32'd316);
        check("reset_by", 32'(dut.by_q), 32'd236);
        check("reset_dxdy", {30'h0, dut.dx_q, dut.dy_q}, 32'h3);
        check("reset_scores", {24'h0, left_score, right_score}, 32'h0);
        check("reset_game_over", 32'(game_over), 32'h0);
        reset = 1'b0;
        step();

        for (int i = 0; i < 3; i++) do_tick();
        check("idle_bx", 32'(dut.bx_q), 32'd316);
        check("idle_by", 32'(dut.by_q), 32'd236);
        check("idle_scores", {24'h0, left_score, right_score}, 32'h0);

        for (int i = 0; i < 18; i++) begin
            pixel(pix[i].r, pix[i].c, pix[i].b);
            check($sformatf("pix%0d_rgb", i), {8'h0, red, green, blue}, {8'h0, pix[i].rgb});
        end

        for (int i = 0; i < 25; i++) begin
            left_paddle_y  = 9'(mv[i].lpy);
            right_paddle_y = 9'(mv[i].rpy);
            serve          = mv[i].srv;
            repeat (mv[i].delta) do_tick();
            check($sformatf("mv%0d_bx", i), 32'(dut.bx_q), 32'(mv[i].bx));
            if (mv[i].chk_y) check($sformatf("mv%0d_by", i), 32'(dut.by_q), 32'(mv[i].by));
            check($sformatf("mv%0d_dx", i), 32'(dut.dx_q), 32'(mv[i].dx));
            check($sformatf("mv%0d_dy", i), 32'(dut.dy_q), 32'(mv[i].dy));
            check($sformatf("mv%0d_lscore", i), 32'(left_score), 32'(mv[i].ls));
            check($sformatf("mv%0d_rscore", i), 32'(right_score), 32'(mv[i].rs));
        end
        check("mid_game_over", 32'(game_over), 32'h0);

        // Remaining right-player points: 60 serve ticks + 158 moves + miss + score.
        for (int p = 2; p <= 9; p++) begin
            repeat (219) do_tick();
            check($sformatf("pt%0d_before", p), 32'(right_score), 32'(p - 1));
            do_tick();
            check($sformatf("pt%0d_after", p), 32'(right_score), 32'(p));
        end
        check("over_game_over", 32'(game_over), 32'h1);
        check("over_lscore", 32'(left_score), 32'd1);

        serve = 1'b1;
        for (int i = 0; i < 5; i++) do_tick();
        serve = 1'b0;
        check("over_frozen_bx", 32'(dut.bx_q), 32'd316);
        check("over_frozen_by", 32'(dut.by_q), 32'd236);
        check("over_still_over", 32'(game_over), 32'h1);
        check("over_scores", {24'h0, left_score, right_score}, 32'h19);
        pixel(236, 316, 0);
        check("over_ball_hidden", {8'h0, red, green, blue}, 32'h0);

        // Reset mid-frame, then confirm the game is back in its initial state.
        row   = 10'd100;
        col   = 10'd200;
        blank = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst2_game_over", 32'(game_over), 32'h0);
        check("rst2_scores", {24'h0, left_score, right_score}, 32'h0);
        check("rst2_dx", 32'(dut.dx_q), 32'h1);
        pixel(240, 320, 0);
        check("rst2_ball_drawn", {8'h0, red, green, blue}, 32'hFFFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
